// File: rtl/bus_xfer_pkg.sv
// Shared types and constants for the '173 bus transfer sequencer.
package bus_xfer_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned OP_W   = 2;

    typedef enum logic [OP_W-1:0] {
        OP_MOVE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        DRIVE   = 2'b01,
        LATCH   = 2'b10,
        RELEASE = 2'b11
    } state_e;

    // '173 control pairs are active low: both low enables the function
    localparam logic [1:0] PAIR_ON  = 2'b00;
    localparam logic [1:0] PAIR_OFF = 2'b11;

    function automatic logic op_uses_src(input op_e op);
        return (op == OP_MOVE) || (op == OP_READ);
    endfunction

    function automatic logic op_uses_dst(input op_e op);
        return (op == OP_MOVE) || (op == OP_WRITE);
    endfunction

endpackage

// File: rtl/bus_xfer_ctrl_if.sv
// Request/response handshake between the host FSM and the transfer sequencer.
interface bus_xfer_ctrl_if #(
    parameter int unsigned NSLOT = 4
);
    localparam int unsigned SEL_W = $clog2(NSLOT);

    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [SEL_W-1:0] req_src;
    logic [SEL_W-1:0] req_dst;
    logic [3:0]       req_data;
    logic             rsp_valid;
    logic [3:0]       rsp_data;
    logic             rsp_err;

    modport master (
        output req_valid, req_op, req_src, req_dst, req_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_src, req_dst, req_data,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/slot_ctl_decode.sv
// One-hot expansion of (state, op, src, dst) into per-slot '173 g/mn pairs.
module slot_ctl_decode
    import bus_xfer_pkg::*;
#(
    parameter int unsigned NSLOT = 4,
    parameter int unsigned SEL_W = $clog2(NSLOT)
) (
    input  state_e             state,
    input  op_e                op,
    input  logic [SEL_W-1:0]   src,
    input  logic [SEL_W-1:0]   dst,
    output logic [2*NSLOT-1:0] slot_g_c,
    output logic [2*NSLOT-1:0] slot_mn_c
);

    logic src_phase;
    logic dst_phase;

    assign src_phase = ((state == DRIVE) || (state == LATCH)) && op_uses_src(op);
    assign dst_phase = (state == LATCH) && op_uses_dst(op);

    always_comb begin
        slot_g_c  = {NSLOT{PAIR_OFF}};
        slot_mn_c = {NSLOT{PAIR_OFF}};
        for (int unsigned i = 0; i < NSLOT; i++) begin
            if (src_phase && (src == SEL_W'(i))) slot_mn_c[2*i +: 2] = PAIR_ON;
            if (dst_phase && (dst == SEL_W'(i))) slot_g_c[2*i +: 2]  = PAIR_ON;
        end
    end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Sequences one MOVE/READ/WRITE at a time over a shared 4-bit tri-state bus
// of '173 registers: IDLE -> DRIVE -> LATCH -> RELEASE.
module bus_xfer_ctrl
    import bus_xfer_pkg::*;
#(
    parameter int unsigned NSLOT = 4
) (
    input  logic               clk,
    input  logic               clr_n,
    bus_xfer_ctrl_if.slave     host,
    output logic [2*NSLOT-1:0] slot_g,
    output logic [2*NSLOT-1:0] slot_mn,
    inout  wire  [3:0]         bus
);

    localparam int unsigned SEL_W = $clog2(NSLOT);
    localparam int unsigned IDX_N = 1 << SEL_W;
    // Bit k set when index k addresses a populated slot
    localparam logic [IDX_N-1:0] IDX_OK = IDX_N'((33'(1) << NSLOT) - 33'(1));

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [SEL_W-1:0]   src_q, src_d;
    logic [SEL_W-1:0]   dst_q, dst_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               err_q, err_d;
    logic               req_bad_c;

    logic [2*NSLOT-1:0] slot_g_c, slot_mn_c;
    logic [2*NSLOT-1:0] slot_g_q, slot_mn_q;
    logic               bus_oe_q;
    logic               req_ready_q;
    logic               rsp_valid_q;
    logic               rsp_err_q;
    logic [DATA_W-1:0]  rsp_data_q;

    // Reject reserved ops and any index the op actually uses that is unpopulated
    always_comb begin
        req_bad_c = 1'b0;
        case (op_e'(host.req_op))
            OP_MOVE:  req_bad_c = !IDX_OK[host.req_src] || !IDX_OK[host.req_dst];
            OP_READ:  req_bad_c = !IDX_OK[host.req_src];
            OP_WRITE: req_bad_c = !IDX_OK[host.req_dst];
            default:  req_bad_c = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src_d   = src_q;
        dst_d   = dst_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (host.req_valid) begin
                    op_d    = op_e'(host.req_op);
                    src_d   = host.req_src;
                    dst_d   = host.req_dst;
                    data_d  = host.req_data;
                    err_d   = req_bad_c;
                    state_d = req_bad_c ? RELEASE : DRIVE;
                end
            end
            DRIVE:   state_d = LATCH;
            LATCH:   state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Decode from next-state values so the registered pairs line up with the state
    slot_ctl_decode #(
        .NSLOT (NSLOT),
        .SEL_W (SEL_W)
    ) u_decode (
        .state     (state_d),
        .op        (op_d),
        .src       (src_d),
        .dst       (dst_d),
        .slot_g_c  (slot_g_c),
        .slot_mn_c (slot_mn_c)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= IDLE;
            op_q        <= OP_MOVE;
            src_q       <= '0;
            dst_q       <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
            slot_g_q    <= {NSLOT{PAIR_OFF}};
            slot_mn_q   <= {NSLOT{PAIR_OFF}};
            bus_oe_q    <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            data_q      <= data_d;
            err_q       <= err_d;
            slot_g_q    <= slot_g_c;
            slot_mn_q   <= slot_mn_c;
            bus_oe_q    <= (op_d == OP_WRITE) && ((state_d == DRIVE) || (state_d == LATCH));
            req_ready_q <= (state_d == IDLE);
            rsp_valid_q <= (state_d == RELEASE);
            rsp_err_q   <= (state_d == RELEASE) && err_d;
            if (state_q == LATCH) begin
                rsp_data_q <= bus;
            end else if ((state_d == RELEASE) && err_d) begin
                rsp_data_q <= '0;
            end
        end
    end

    assign bus            = bus_oe_q ? data_q : 4'bz;
    assign slot_g         = slot_g_q;
    assign slot_mn        = slot_mn_q;
    assign host.req_ready = req_ready_q;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_err   = rsp_err_q;
    assign host.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Randomized bench for bus_xfer_ctrl with a '173 register-file model on the bus
// and an array-based reference of the expected register contents.
module tb_bus_xfer_ctrl;
    import bus_xfer_pkg::*;

    localparam int unsigned NSLOT  = 4;
    localparam int unsigned NSLOT3 = 3;

    logic clk   = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    bus_xfer_ctrl_if #(.NSLOT(NSLOT))  ifc ();
    bus_xfer_ctrl_if #(.NSLOT(NSLOT3)) ifc3 ();

    logic [2*NSLOT-1:0]  slot_g, slot_mn;
    logic [2*NSLOT3-1:0] slot_g3, slot_mn3;
    wire  [3:0]          bus;
    wire  [3:0]          bus3;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [3:0] slot_val [NSLOT] = '{default: 4'h0};
    logic [3:0] ref_reg  [NSLOT] = '{default: 4'h0};
    logic       drv_en;
    logic [3:0] drv_val;

    bus_xfer_ctrl #(.NSLOT(NSLOT)) u_dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .host    (ifc),
        .slot_g  (slot_g),
        .slot_mn (slot_mn),
        .bus     (bus)
    );

    bus_xfer_ctrl #(.NSLOT(NSLOT3)) u_dut3 (
        .clk     (clk),
        .clr_n   (clr_n),
        .host    (ifc3),
        .slot_g  (slot_g3),
        .slot_mn (slot_mn3),
        .bus     (bus3)
    );

    // '173 slots: output when both mn low, load from bus when both g low
    always_comb begin
        drv_en  = 1'b0;
        drv_val = 4'h0;
        for (int i = 0; i < NSLOT; i++) begin
            if (slot_mn[2*i +: 2] == 2'b00) begin
                drv_en  = 1'b1;
                drv_val = slot_val[i];
            end
        end
    end
    assign bus = drv_en ? drv_val : 4'bz;

    always @(posedge clk) begin
        for (int i = 0; i < NSLOT; i++)
            if (slot_g[2*i +: 2] == 2'b00) slot_val[i] <= bus;
    end

    task automatic do_xfer(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                           input logic [3:0] data, input bit hold);
        bit                 bad;
        int                 nph;
        int                 wait_n;
        logic [3:0]         exp_val;
        logic [2*NSLOT-1:0] eg, em;
        bad = (op == 2'b11);
        case (op)
            2'b00, 2'b01: exp_val = ref_reg[src];
            2'b10:        exp_val = data;
            default:      exp_val = 4'h0;
        endcase
        nph = bad ? 1 : 3;
        ifc.req_valid = 1'b1;
        ifc.req_op    = op;
        ifc.req_src   = src;
        ifc.req_dst   = dst;
        ifc.req_data  = data;
        wait_n = 0;
        while (ifc.req_ready !== 1'b1 && wait_n < 10) begin
            @(negedge clk);
            wait_n++;
        end
        if (wait_n == 10) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout: req_ready never 1 within 10 cycles");
        end
        for (int k = 1; k <= nph; k++) begin
            @(negedge clk);
            if (!hold) ifc.req_valid = 1'b0;
            ifc.req_op   = 2'($urandom);
            ifc.req_src  = 2'($urandom);
            ifc.req_dst  = 2'($urandom);
            ifc.req_data = 4'($urandom);
            eg = '1;
            em = '1;
            if (!bad && k <= 2 && (op == 2'b00 || op == 2'b01)) em[2*int'(src) +: 2] = 2'b00;
            if (!bad && k == 2 && (op == 2'b00 || op == 2'b10)) eg[2*int'(dst) +: 2] = 2'b00;
            n_cmp++;
            if (slot_g !== eg) begin
                n_fail++;
                $display("FAIL slot_g op=%0d ph=%0d: got %b want %b", op, k, slot_g, eg);
            end
            n_cmp++;
            if (slot_mn !== em) begin
                n_fail++;
                $display("FAIL slot_mn op=%0d ph=%0d: got %b want %b", op, k, slot_mn, em);
            end
            n_cmp++;
            if (ifc.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL req_ready_busy ph=%0d: got %b want 0", k, ifc.req_ready);
            end
            n_cmp++;
            if (ifc.rsp_valid !== (k == nph)) begin
                n_fail++;
                $display("FAIL rsp_valid op=%0d ph=%0d: got %b want %b", op, k, ifc.rsp_valid, k == nph);
            end
            if (!bad && k <= 2) begin
                n_cmp++;
                if (bus !== exp_val) begin
                    n_fail++;
                    $display("FAIL bus op=%0d ph=%0d: got %h want %h", op, k, bus, exp_val);
                end
            end
            if (k == nph) begin
                n_cmp++;
                if (ifc.rsp_data !== exp_val) begin
                    n_fail++;
                    $display("FAIL rsp_data op=%0d: got %h want %h", op, ifc.rsp_data, exp_val);
                end
                n_cmp++;
                if (ifc.rsp_err !== bad) begin
                    n_fail++;
                    $display("FAIL rsp_err op=%0d: got %b want %b", op, ifc.rsp_err, bad);
                end
            end
        end
        if (!bad && (op == 2'b00 || op == 2'b10)) ref_reg[dst] = exp_val;
        for (int i = 0; i < NSLOT; i++) begin
            n_cmp++;
            if (slot_val[i] !== ref_reg[i]) begin
                n_fail++;
                $display("FAIL slot%0d_value: got %h want %h", i, slot_val[i], ref_reg[i]);
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (ifc.req_ready !== 1'b1 || ifc.rsp_valid !== 1'b0 || ifc.rsp_err !== 1'b0 || ifc.rsp_data !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_rsp: rdy=%b vld=%b err=%b data=%h want 1 0 0 0",
                     ifc.req_ready, ifc.rsp_valid, ifc.rsp_err, ifc.rsp_data);
        end
        n_cmp++;
        if (slot_g !== '1 || slot_mn !== '1) begin
            n_fail++;
            $display("FAIL reset_pairs: g=%b mn=%b want all ones", slot_g, slot_mn);
        end
        n_cmp++;
        if (ifc3.req_ready !== 1'b1 || slot_g3 !== '1 || slot_mn3 !== '1) begin
            n_fail++;
            $display("FAIL reset_dut3: rdy=%b g=%b mn=%b want 1 and all ones", ifc3.req_ready, slot_g3, slot_mn3);
        end
        clr_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ifc.req_ready !== 1'b1 || ifc.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: rdy=%b vld=%b want 1 0", ifc.req_ready, ifc.rsp_valid);
        end
    endtask

    task automatic test_write;
        do_xfer(2'b10, 2'd0, 2'd2, 4'hA, 1'b0);
    endtask

    task automatic test_move;
        do_xfer(2'b10, 2'd0, 2'd1, 4'h5, 1'b0);
        do_xfer(2'b10, 2'd0, 2'd3, 4'h0, 1'b0);
        do_xfer(2'b00, 2'd1, 2'd3, 4'h0, 1'b0);
        do_xfer(2'b00, 2'd2, 2'd2, 4'h7, 1'b0);
    endtask

    task automatic test_read;
        do_xfer(2'b10, 2'd0, 2'd0, 4'hC, 1'b0);
        do_xfer(2'b01, 2'd0, 2'd1, 4'h3, 1'b0);
    endtask

    task automatic test_reject;
        int wait_n;
        do_xfer(2'b11, 2'd1, 2'd2, 4'h9, 1'b0);
        // Out-of-range indices on the 3-slot instance: MOVE, READ, WRITE, reserved
        for (int k = 0; k < 4; k++) begin
            ifc3.req_valid = 1'b1;
            ifc3.req_op    = 2'(k);
            ifc3.req_src   = (k == 2) ? 2'd0 : 2'd3;
            ifc3.req_dst   = (k == 0 || k == 2) ? 2'd3 : 2'd0;
            ifc3.req_data  = 4'hF;
            wait_n = 0;
            while (ifc3.req_ready !== 1'b1 && wait_n < 10) begin
                @(negedge clk);
                wait_n++;
            end
            if (wait_n == 10) begin
                n_cmp++; n_fail++;
                $display("FAIL dut3_accept_timeout op=%0d", k);
            end
            @(negedge clk);
            ifc3.req_valid = 1'b0;
            n_cmp++;
            if (ifc3.rsp_valid !== 1'b1 || ifc3.rsp_err !== 1'b1 || ifc3.rsp_data !== 4'h0) begin
                n_fail++;
                $display("FAIL range_err op=%0d: vld=%b err=%b data=%h want 1 1 0",
                         k, ifc3.rsp_valid, ifc3.rsp_err, ifc3.rsp_data);
            end
            n_cmp++;
            if (slot_g3 !== '1 || slot_mn3 !== '1 || ifc3.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL range_quiet op=%0d: g=%b mn=%b rdy=%b want ones ones 0", k, slot_g3, slot_mn3, ifc3.req_ready);
            end
            @(negedge clk);
            n_cmp++;
            if (ifc3.rsp_valid !== 1'b0 || ifc3.req_ready !== 1'b1 || slot_g3 !== '1 || slot_mn3 !== '1) begin
                n_fail++;
                $display("FAIL range_idle op=%0d: vld=%b rdy=%b g=%b mn=%b", k, ifc3.rsp_valid, ifc3.req_ready, slot_g3, slot_mn3);
            end
        end
    endtask

    task automatic test_reset_mid;
        int wait_n;
        ifc.req_valid = 1'b1;
        ifc.req_op    = 2'b00;
        ifc.req_src   = 2'd2;
        ifc.req_dst   = 2'd0;
        ifc.req_data  = 4'h0;
        wait_n = 0;
        while (ifc.req_ready !== 1'b1 && wait_n < 10) begin
            @(negedge clk);
            wait_n++;
        end
        if (wait_n == 10) begin
            n_cmp++; n_fail++;
            $display("FAIL mid_accept_timeout");
        end
        @(negedge clk);
        ifc.req_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (slot_g[1:0] !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_latch_g: got %b want 00", slot_g[1:0]);
        end
        clr_n = 1'b0;
        #1;
        n_cmp++;
        if (slot_g !== '1 || slot_mn !== '1 || ifc.req_ready !== 1'b1 || ifc.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_clear: g=%b mn=%b rdy=%b vld=%b", slot_g, slot_mn, ifc.req_ready, ifc.rsp_valid);
        end
        @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ifc.rsp_valid !== 1'b0 || ifc.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL after_clear: vld=%b rdy=%b want 0 1", ifc.rsp_valid, ifc.req_ready);
        end
        n_cmp++;
        if (slot_val[0] !== ref_reg[0]) begin
            n_fail++;
            $display("FAIL abandoned_dst: got %h want %h", slot_val[0], ref_reg[0]);
        end
    endtask

    task automatic test_back_to_back;
        for (int n = 0; n < 20; n++)
            do_xfer(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 4'($urandom), 1'b1);
        ifc.req_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ifc.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_idle: req_ready got %b want 1", ifc.req_ready);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        ifc.req_valid  = 1'b0;
        ifc.req_op     = 2'b00;
        ifc.req_src    = '0;
        ifc.req_dst    = '0;
        ifc.req_data   = 4'h0;
        ifc3.req_valid = 1'b0;
        ifc3.req_op    = 2'b00;
        ifc3.req_src   = '0;
        ifc3.req_dst   = '0;
        ifc3.req_data  = 4'h0;
        test_reset();
        test_write();
        test_move();
        test_read();
        test_reject();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_xfer_ctrl.md
Name: bus_xfer_ctrl

Overview:
- Sequencer for a shared 4-bit tri-state bus populated by NSLOT 4-bit registers with the '173 interface: load-enable pair g (both low = load on posedge clk) and output-disable pair mn (either high = output Z).
- Accepts one transfer request at a time and drives the slots' g/mn so that data moves register→register (MOVE), register→host (READ) or host→register (WRITE).
- Holds its own tri-state driver on the bus for WRITE.
- Sits between a host/controller FSM and the register file.

Parameters:
NSLOT, 4, number of register slots on the bus (2..16)
SEL_W, $clog2(NSLOT), width of slot index (derived, not overridden)

Ports:
clk  input  1  clock; all state changes on posedge
clr_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept request (high only in IDLE)
req_op  input  2  00 MOVE, 01 READ, 10 WRITE, 11 reserved
req_src  input  SEL_W  source slot (MOVE/READ)
req_dst  input  SEL_W  destination slot (MOVE/WRITE)
req_data  input  4  write data (WRITE)
rsp_valid  output  1  one-cycle completion pulse
rsp_data  output  4  bus value captured in LATCH (MOVE/READ/WRITE)
rsp_err  output  1  qualified by rsp_valid; request rejected
slot_g  output  2*NSLOT  per-slot g pair, slot i at [2i+1:2i]
slot_mn  output  2*NSLOT  per-slot mn pair, slot i at [2i+1:2i]
bus  inout  4  shared data bus; driven only in WRITE DRIVE/LATCH, else 'z

Behaviour:
- Reset: clr_n low asynchronously forces the following; all hold until the first posedge with clr_n high. Applies equally mid-transfer (transfer abandoned, no rsp).
  - FSM in IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0
  - every slot_g pair = 2'b11, every slot_mn pair = 2'b11, bus = 'z
- States: IDLE → DRIVE → LATCH → RELEASE → IDLE.
- IDLE:
  - req_ready=1.
  - On posedge with req_valid, the request is registered.
  - Rejection: if req_op=11, or any used index ≥ NSLOT, go to RELEASE with err flag set. There is no bus activity.
  - Otherwise go to DRIVE.
- DRIVE (1 cycle):
  - MOVE/READ: src mn=2'b00; all other mn=2'b11.
  - WRITE: all mn=2'b11; bus driven with registered data.
  - All g=2'b11.
- LATCH (1 cycle):
  - Same mn/bus as DRIVE.
  - MOVE/WRITE: dst g=2'b00; the slot loads at the closing posedge.
  - READ: all g=2'b11.
  - At the closing posedge, rsp_data register captures bus.
- RELEASE (1 cycle):
  - All g=2'b11, all mn=2'b11, bus='z.
  - rsp_valid=1; rsp_err=err flag; rsp_data=captured value, or 0 if err.
- Latency: accept edge to rsp_valid is 3 cycles (err: 1 cycle). Throughput is one transfer per 4 cycles.
- rsp_valid is a pulse with no backpressure. req_ready=0 outside IDLE; req_valid there is ignored.
- Invariants every cycle:
  - at most one slot has mn=2'b00
  - never a slot mn=2'b00 while the block drives bus
  - at most one slot has g=2'b00, and only in LATCH
  - g/mn are registered outputs, glitch-free
- MOVE with src==dst is legal: the slot reloads its own value.
- No combinational path from req_* to slot_g/slot_mn/bus.

Decomposition:
- Package bus_xfer_pkg:
  - op_e enum (OP_MOVE, OP_READ, OP_WRITE, OP_RSVD)
  - state_e enum (IDLE, DRIVE, LATCH, RELEASE)
  - constants PAIR_ON=2'b00, PAIR_OFF=2'b11
- Sub-module slot_ctl_decode: combinational one-hot expansion of (state, op, src, dst) into slot_g/slot_mn vectors, registered in the top.

Test Plan:
1. Reset, then WRITE dst=2 data=4'hA → dst 2 g=00 only in LATCH; rsp_valid on the 3rd cycle after accept, rsp_data=A, err=0; model slot 2 = A.
2. Preload slot1=5 and slot3=0, MOVE src=1 dst=3 → slot1 mn=00 in DRIVE+LATCH, slot3 g=00 in LATCH; slot3=5; rsp_data=5.
3. READ src=0 (slot0=C) → no g pair ever 00; rsp_data=C; all slots unchanged.
4. req_op=11, then MOVE with NSLOT=3 and src=3 → rsp_valid the cycle after accept with err=1, rsp_data=0; all g/mn stay 11 and bus stays Z throughout.
5. clr_n low during LATCH of a MOVE → immediately all pairs 11, bus Z, req_ready=1; no rsp_valid; destination unchanged.
6. Back-to-back 20 random requests with req_valid held high → req_ready high only in IDLE; bus contention and one-hot assertions never fire; scoreboard matches.
